// File: rtl/fifo_capture_ctrl_if.sv
// Command, FIFO-strobe and host read-back signals of fifo_capture_ctrl.
// master is the controller side, slave is the FIFO/host side.
interface fifo_capture_ctrl_if #(
    parameter int unsigned CNT_W = 32
) ();
    logic             cfg_start;
    logic             cfg_abort;
    logic [CNT_W-1:0] cfg_len;
    logic [7:0]       cfg_div;
    logic             fifo_rst;
    logic             fifo_wr_en;
    logic [63:0]      fifo_din;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic [63:0]      fifo_dout;
    logic             pop;
    logic [63:0]      data;
    logic             data_vld;
    logic [2:0]       state;
    logic             busy;
    logic             done;
    logic             ovf;
    logic [CNT_W-1:0] wr_count;

    modport master (
        input  cfg_start, cfg_abort, cfg_len, cfg_div, fifo_full, fifo_empty, fifo_dout, pop,
        output fifo_rst, fifo_wr_en, fifo_din, fifo_rd_en, data, data_vld, state, busy, done,
               ovf, wr_count
    );

    modport slave (
        output cfg_start, cfg_abort, cfg_len, cfg_div, fifo_full, fifo_empty, fifo_dout, pop,
        input  fifo_rst, fifo_wr_en, fifo_din, fifo_rd_en, data, data_vld, state, busy, done,
               ovf, wr_count
    );
endinterface

// File: rtl/fifo_capture_ctrl.sv
// Timestamp-capture FIFO sequencer: flush, decimated tick writes, then drain into a
// single holding register that the host pops word by word.
module fifo_capture_ctrl #(
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned FLUSH_CYC = 4
) (
    input logic                 clk,
    input logic                 rst,
    fifo_capture_ctrl_if.master bus
);
    localparam int unsigned FLUSH_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYC - 1);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StFlush   = 3'd1,
        StCapture = 3'd2,
        StDrain   = 3'd3,
        StDone    = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [7:0]         div_q, div_d;
    logic [7:0]         div_cnt_q, div_cnt_d;
    logic [63:0]        tick_idx_q, tick_idx_d;
    logic [CNT_W-1:0]   wr_count_q, wr_count_d;
    logic               ovf_q, ovf_d;
    logic               abort_q, abort_d;
    logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
    logic               rd_pend_q, rd_pend_d;
    logic [63:0]        data_q, data_d;
    logic               data_vld_q, data_vld_d;
    logic               wr_en, rd_en, tick, busy;

    assign tick = (div_cnt_q == div_q);
    assign busy = (state_q == StFlush) || (state_q == StCapture) || (state_q == StDrain);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            len_q       <= '0;
            div_q       <= '0;
            div_cnt_q   <= '0;
            tick_idx_q  <= '0;
            wr_count_q  <= '0;
            ovf_q       <= 1'b0;
            abort_q     <= 1'b0;
            flush_cnt_q <= '0;
            rd_pend_q   <= 1'b0;
            data_q      <= '0;
            data_vld_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            div_q       <= div_d;
            div_cnt_q   <= div_cnt_d;
            tick_idx_q  <= tick_idx_d;
            wr_count_q  <= wr_count_d;
            ovf_q       <= ovf_d;
            abort_q     <= abort_d;
            flush_cnt_q <= flush_cnt_d;
            rd_pend_q   <= rd_pend_d;
            data_q      <= data_d;
            data_vld_q  <= data_vld_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        div_d       = div_q;
        div_cnt_d   = div_cnt_q;
        tick_idx_d  = tick_idx_q;
        wr_count_d  = wr_count_q;
        ovf_d       = ovf_q;
        abort_d     = abort_q;
        flush_cnt_d = flush_cnt_q;
        rd_pend_d   = rd_pend_q;
        data_d      = data_q;
        data_vld_d  = data_vld_q;
        wr_en       = 1'b0;
        rd_en       = 1'b0;

        // Abort outranks start and suppresses any strobe in the same cycle.
        if (bus.cfg_abort) begin
            if (busy) begin
                abort_d     = 1'b1;
                data_vld_d  = 1'b0;
                rd_pend_d   = 1'b0;
                flush_cnt_d = '0;
                state_d     = StFlush;
            end else begin
                abort_d = 1'b0;
                state_d = StIdle;
            end
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (bus.cfg_start) begin
                        len_d       = bus.cfg_len;
                        div_d       = bus.cfg_div;
                        ovf_d       = 1'b0;
                        wr_count_d  = '0;
                        tick_idx_d  = '0;
                        data_vld_d  = 1'b0;
                        flush_cnt_d = '0;
                        state_d     = StFlush;
                    end
                end
                StFlush: begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                    if (flush_cnt_q == FLUSH_LAST) begin
                        if (abort_q) begin
                            abort_d = 1'b0;
                            state_d = StIdle;
                        end else begin
                            div_cnt_d = '0;
                            state_d   = StCapture;
                        end
                    end
                end
                StCapture: begin
                    div_cnt_d = tick ? 8'd0 : div_cnt_q + 8'd1;
                    if (wr_count_q >= len_q) begin
                        state_d = StDrain;
                    end else if (tick) begin
                        if (bus.fifo_full) begin
                            ovf_d   = 1'b1;
                            state_d = StDrain;
                        end else begin
                            wr_en      = 1'b1;
                            tick_idx_d = tick_idx_q + 64'd1;
                            if (wr_count_q != '1) wr_count_d = wr_count_q + 1'b1;
                            if ((wr_count_q + 1'b1) == len_q) state_d = StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (rd_pend_q) begin
                        data_d     = bus.fifo_dout;
                        data_vld_d = 1'b1;
                        rd_pend_d  = 1'b0;
                    end else if (data_vld_q) begin
                        if (bus.pop) data_vld_d = 1'b0;
                    end else if (!bus.fifo_empty) begin
                        rd_en     = 1'b1;
                        rd_pend_d = 1'b1;
                    end else begin
                        state_d = StDone;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign bus.fifo_rst   = (state_q == StFlush);
    assign bus.fifo_wr_en = wr_en;
    assign bus.fifo_din   = tick_idx_q;
    assign bus.fifo_rd_en = rd_en;
    assign bus.data       = data_q;
    assign bus.data_vld   = data_vld_q;
    assign bus.state      = state_q;
    assign bus.busy       = busy;
    assign bus.done       = (state_q == StDone);
    assign bus.ovf        = ovf_q;
    assign bus.wr_count   = wr_count_q;
endmodule

// File: tb/tb_fifo_capture_ctrl.sv
// Bench for fifo_capture_ctrl with a behavioural 64-deep FIFO whose full level is adjustable.
module tb_fifo_capture_ctrl;
    localparam int unsigned CNT_W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_capture_ctrl_if #(.CNT_W(CNT_W)) bus ();
    fifo_capture_ctrl #(.CNT_W(CNT_W), .FLUSH_CYC(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    // FIFO model: write/read sampled at the clock edge, dout valid the cycle after rd_en.
    logic [63:0] mem [64];
    logic [6:0]  wp, rp, cnt;
    logic [6:0]  cap = 7'd64;
    logic [63:0] dout_r;
    logic        fw, fr;
    assign bus.fifo_empty = (cnt == 7'd0);
    assign bus.fifo_full  = (cnt >= cap);
    assign bus.fifo_dout  = dout_r;
    assign fw = bus.fifo_wr_en && !bus.fifo_full;
    assign fr = bus.fifo_rd_en && !bus.fifo_empty;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0; rp <= '0; cnt <= '0; dout_r <= '0;
        end else if (bus.fifo_rst) begin
            wp <= '0; rp <= '0; cnt <= '0;
        end else begin
            if (fw) begin mem[wp[5:0]] <= bus.fifo_din; wp <= wp + 7'd1; end
            if (fr) begin dout_r <= mem[rp[5:0]]; rp <= rp + 7'd1; end
            cnt <= cnt + {6'd0, fw} - {6'd0, fr};
        end
    end

    typedef struct packed { int unsigned cyc; logic [63:0] val; } wr_t;
    int unsigned cyc = 0;
    wr_t         wr_log[$];
    int unsigned wr_pulses = 0, rd_pulses = 0, frst_cycles = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (bus.fifo_wr_en === 1'b1) begin
            wr_log.push_back({cyc, bus.fifo_din});
            wr_pulses <= wr_pulses + 1;
        end
        if (bus.fifo_rd_en === 1'b1) rd_pulses <= rd_pulses + 1;
        if (bus.fifo_rst === 1'b1) frst_cycles <= frst_cycles + 1;
    end

    int n_cmp = 0, n_fail = 0;
    wr_t         exp_wr[$];
    logic [63:0] exp_rd[$];
    logic [63:0] got_q[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input logic [CNT_W-1:0] len, input logic [7:0] div,
                             output int unsigned c0);
        wr_log.delete();
        bus.cfg_len = len; bus.cfg_div = div; bus.cfg_start = 1'b1;
        c0 = cyc;
        step();
        bus.cfg_start = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, output bit ok);
        int i = 0;
        while (bus.state !== st && i < budget) begin step(); i++; end
        ok = (bus.state === st);
    endtask

    task automatic drain_collect(input int budget, output bit ok);
        int i = 0;
        got_q.delete();
        while (bus.state !== 3'd4 && i < budget) begin
            if (bus.data_vld === 1'b1) begin got_q.push_back(bus.data); bus.pop = 1'b1; end
            else bus.pop = 1'b0;
            step(); i++;
        end
        bus.pop = 1'b0;
        ok = (bus.state === 3'd4);
    endtask

    task automatic test_reset();
        logic [135:0] outs;
        rst = 1'b1;
        bus.cfg_start = 1'b0; bus.cfg_abort = 1'b0; bus.cfg_len = '0; bus.cfg_div = '0;
        bus.pop = 1'b0;
        step(); step();
        outs = {bus.fifo_rst, bus.fifo_wr_en, bus.fifo_rd_en, bus.data_vld, bus.busy, bus.done,
                bus.ovf, bus.wr_count, bus.data, bus.state, 29'd0};
        n_cmp++;
        if (outs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", outs); end
        n_cmp++;
        if (bus.fifo_din !== 64'd0) begin
            n_fail++; $display("FAIL reset_din: got %h want 0", bus.fifo_din);
        end
        rst = 1'b0;
        step();
        n_cmp++;
        if (bus.state !== 3'd0) begin n_fail++; $display("FAIL idle_after_reset: got %0d want 0", bus.state); end
    endtask

    task automatic test_basic();
        int unsigned c0; bit ok; wr_t e, a; logic [63:0] x;
        exp_wr.delete(); exp_rd.delete();
        start_cmd(5, 0, c0);
        for (int k = 0; k < 5; k++) begin
            exp_wr.push_back({c0 + 5 + k, 64'(k)});
            exp_rd.push_back(64'(k));
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({bus.state, bus.fifo_rst} !== {3'd1, 1'b1}) begin
                n_fail++; $display("FAIL basic_flush[%0d]: got state %0d rst %b want 1/1", i, bus.state, bus.fifo_rst);
            end
            step();
        end
        n_cmp++;
        if ({bus.state, bus.fifo_rst} !== {3'd2, 1'b0}) begin
            n_fail++; $display("FAIL basic_capture_entry: got state %0d rst %b want 2/0", bus.state, bus.fifo_rst);
        end
        wait_state(3'd3, 50, ok);
        n_cmp++;
        if (!ok || cyc !== c0 + 10) begin
            n_fail++; $display("FAIL basic_drain_entry: got cycle %0d want %0d", cyc - c0, 10);
        end
        n_cmp++;
        if (wr_log.size() !== exp_wr.size()) begin
            n_fail++; $display("FAIL basic_write_count: got %0d want %0d", wr_log.size(), exp_wr.size());
        end
        while (exp_wr.size() > 0 && wr_log.size() > 0) begin
            e = exp_wr.pop_front(); a = wr_log.pop_front();
            n_cmp++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL basic_write: got cyc+%0d val %0d want cyc+%0d val %0d", a.cyc - c0, a.val, e.cyc - c0, e.val);
            end
        end
        drain_collect(200, ok);
        n_cmp++;
        if (!ok || got_q.size() !== exp_rd.size()) begin
            n_fail++; $display("FAIL basic_drain_count: got %0d want %0d", got_q.size(), exp_rd.size());
        end
        while (exp_rd.size() > 0 && got_q.size() > 0) begin
            x = exp_rd.pop_front();
            n_cmp++;
            if (got_q[0] !== x) begin n_fail++; $display("FAIL basic_drain_data: got %0d want %0d", got_q[0], x); end
            void'(got_q.pop_front());
        end
        n_cmp++;
        if ({bus.done, bus.busy, bus.data_vld, bus.ovf, bus.wr_count, bus.data} !== {4'b1000, 32'd5, 64'd4}) begin
            n_fail++;
            $display("FAIL basic_done: got done %b busy %b vld %b ovf %b cnt %0d data %0d want 1 0 0 0 5 4",
                     bus.done, bus.busy, bus.data_vld, bus.ovf, bus.wr_count, bus.data);
        end
    endtask

    task automatic test_spacing();
        int unsigned c0; bit ok; wr_t e, a;
        exp_wr.delete();
        start_cmd(3, 2, c0);
        for (int k = 0; k < 3; k++) exp_wr.push_back({c0 + 5 + k * 3 + 2, 64'(k)});
        wait_state(3'd3, 60, ok);
        n_cmp++;
        if (!ok || cyc !== c0 + 14) begin
            n_fail++; $display("FAIL spacing_drain_entry: got cycle %0d want 14", cyc - c0);
        end
        n_cmp++;
        if (wr_log.size() !== 3) begin n_fail++; $display("FAIL spacing_count: got %0d want 3", wr_log.size()); end
        while (exp_wr.size() > 0 && wr_log.size() > 0) begin
            e = exp_wr.pop_front(); a = wr_log.pop_front();
            n_cmp++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL spacing_write: got cyc+%0d val %0d want cyc+%0d val %0d", a.cyc - c0, a.val, e.cyc - c0, e.val);
            end
        end
        drain_collect(200, ok);
        n_cmp++;
        if (!ok || got_q.size() !== 3 || got_q[0] !== 64'd0 || got_q[2] !== 64'd2) begin
            n_fail++; $display("FAIL spacing_drain: got %0d words want 3 (0..2)", got_q.size());
        end
    endtask

    task automatic test_overflow();
        int unsigned c0; bit ok; logic [63:0] x;
        exp_rd.delete();
        cap = 7'd16;
        start_cmd(20, 0, c0);
        for (int k = 0; k < 16; k++) exp_rd.push_back(64'(k));
        wait_state(3'd3, 80, ok);
        n_cmp++;
        if (!ok || cyc !== c0 + 22) begin
            n_fail++; $display("FAIL ovf_drain_entry: got cycle %0d want 22", cyc - c0);
        end
        n_cmp++;
        if ({bus.ovf, bus.wr_count} !== {1'b1, 32'd16} || wr_log.size() !== 16) begin
            n_fail++;
            $display("FAIL ovf_flags: got ovf %b cnt %0d writes %0d want 1 16 16", bus.ovf, bus.wr_count, wr_log.size());
        end
        drain_collect(300, ok);
        n_cmp++;
        if (!ok || got_q.size() !== 16) begin
            n_fail++; $display("FAIL ovf_drain_count: got %0d want 16", got_q.size());
        end
        while (exp_rd.size() > 0 && got_q.size() > 0) begin
            x = exp_rd.pop_front();
            n_cmp++;
            if (got_q[0] !== x) begin n_fail++; $display("FAIL ovf_drain_data: got %0d want %0d", got_q[0], x); end
            void'(got_q.pop_front());
        end
        n_cmp++;
        if ({bus.done, bus.ovf} !== 2'b11) begin
            n_fail++; $display("FAIL ovf_sticky: got done %b ovf %b want 1 1", bus.done, bus.ovf);
        end
        cap = 7'd64;
    endtask

    task automatic test_abort();
        int unsigned c0; wr_t a;
        start_cmd(10, 1, c0);
        while (cyc < c0 + 10) step();
        bus.cfg_abort = 1'b1;
        #1;
        n_cmp++;
        if ({bus.state, bus.fifo_wr_en} !== {3'd2, 1'b0}) begin
            n_fail++; $display("FAIL abort_no_write: got state %0d wr_en %b want 2 0", bus.state, bus.fifo_wr_en);
        end
        step();
        bus.cfg_abort = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({bus.state, bus.fifo_rst} !== {3'd1, 1'b1}) begin
                n_fail++; $display("FAIL abort_flush[%0d]: got state %0d rst %b want 1/1", i, bus.state, bus.fifo_rst);
            end
            step();
        end
        n_cmp++;
        if ({bus.state, bus.done, bus.data_vld, bus.busy, bus.ovf} !== {3'd0, 4'b0000}) begin
            n_fail++;
            $display("FAIL abort_idle: got state %0d done %b vld %b busy %b ovf %b want 0 0 0 0 0",
                     bus.state, bus.done, bus.data_vld, bus.busy, bus.ovf);
        end
        n_cmp++;
        if (wr_log.size() !== 2) begin
            n_fail++; $display("FAIL abort_write_count: got %0d want 2", wr_log.size());
        end else begin
            a = wr_log[1];
            n_cmp++;
            if (a !== {c0 + 8, 64'd1}) begin
                n_fail++; $display("FAIL abort_last_write: got cyc+%0d val %0d want cyc+8 val 1", a.cyc - c0, a.val);
            end
        end
    endtask

    task automatic test_start_abort();
        int unsigned c0, f0; bit ok;
        f0 = frst_cycles;
        bus.cfg_len = 5; bus.cfg_start = 1'b1; bus.cfg_abort = 1'b1;
        step();
        bus.cfg_start = 1'b0; bus.cfg_abort = 1'b0;
        step(); step(); step();
        n_cmp++;
        if (bus.state !== 3'd0 || frst_cycles !== f0) begin
            n_fail++; $display("FAIL start_abort_same: got state %0d flush cycles %0d want 0 0", bus.state, frst_cycles - f0);
        end
        start_cmd(4, 0, c0);
        wait_state(3'd3, 50, ok);
        step(); step();
        bus.cfg_len = 9; bus.cfg_start = 1'b1;
        step();
        bus.cfg_start = 1'b0;
        n_cmp++;
        if ({ok, bus.state, bus.fifo_rst} !== {1'b1, 3'd3, 1'b0}) begin
            n_fail++; $display("FAIL start_in_drain: got state %0d rst %b want 3 0", bus.state, bus.fifo_rst);
        end
        drain_collect(200, ok);
        n_cmp++;
        if (!ok || got_q.size() !== 4 || got_q[3] !== 64'd3 || bus.wr_count !== 32'd4) begin
            n_fail++; $display("FAIL start_in_drain_result: got %0d words cnt %0d want 4 4", got_q.size(), bus.wr_count);
        end
    endtask

    task automatic test_len_zero();
        int unsigned c0, w0, r0;
        w0 = wr_pulses; r0 = rd_pulses;
        start_cmd(0, 3, c0);
        step(); step(); step(); step();
        n_cmp++;
        if (bus.state !== 3'd2) begin n_fail++; $display("FAIL len0_capture: got %0d want 2", bus.state); end
        step();
        n_cmp++;
        if (bus.state !== 3'd3) begin n_fail++; $display("FAIL len0_drain: got %0d want 3", bus.state); end
        step();
        n_cmp++;
        if (bus.state !== 3'd4) begin n_fail++; $display("FAIL len0_done: got %0d want 4", bus.state); end
        n_cmp++;
        if (wr_pulses !== w0 || rd_pulses !== r0 || bus.wr_count !== 32'd0) begin
            n_fail++;
            $display("FAIL len0_strobes: got wr %0d rd %0d cnt %0d want 0 0 0", wr_pulses - w0, rd_pulses - r0, bus.wr_count);
        end
    endtask

    task automatic test_async_reset();
        int unsigned c0;
        start_cmd(10, 0, c0);
        for (int i = 0; i < 6; i++) step();
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.state, bus.fifo_rst, bus.busy, bus.wr_count, bus.data} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got state %0d rst %b busy %b cnt %0d data %0d want all 0",
                     bus.state, bus.fifo_rst, bus.busy, bus.wr_count, bus.data);
        end
        #2;
        rst = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_spacing();
        test_overflow();
        test_abort();
        test_start_abort();
        test_len_zero();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog");
    end
endmodule
